// File: rtl/cmd_emitter.sv
// cmd_emitter: turns a small command code into its ASCII text ("G00", "G91",
// "M02", ...) and writes it one character at a time to a character sink.
// Optional build macro CMD_EMITTER_TRAILING_SPACE_EN appends an ASCII space
// after every valid command.
//
// Sink handshake: in WAIT_RDY the emitter waits for wr_rdy=1, then raises
// wr_trigger for exactly one state cycle with char_out registered alongside;
// the sink answers with wr_done=1, which is only looked at in WAIT_DONE.
// All state, including the outputs, advances only when clk_en=1.
module cmd_emitter #(
  parameter int CMD_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                trigger,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                wr_rdy,
  input  logic                wr_done,
  output logic                rdy,
  output logic                done,
  output logic                success,
  output logic                wr_trigger,
  output logic [7:0]          char_out,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_WRITE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

`ifdef CMD_EMITTER_TRAILING_SPACE_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  state_t              state_q;
  logic [CMD_BITS-1:0] cmd_q;
  logic [1:0]          idx_q;
  logic                rdy_q;
  logic                done_q;
  logic                success_q;
  logic                wr_trigger_q;
  logic [7:0]          char_q;

  logic [7:0]          char_d;
  logic [7:0]          letter;
  logic [3:0]          tens;
  logic [3:0]          ones;
  logic                cmd_valid;

  // Full-width compare: any code of 7 or above is not a command.
  assign cmd_valid = (32'(cmd_q) < 32'd7);

  // Character at the current index of the latched command text.
  always_comb begin
    letter = 8'h47;
    tens   = 4'd0;
    ones   = 4'd0;
    char_d = 8'h00;
    case (cmd_q)
      CMD_BITS'(0): ones = 4'd0;
      CMD_BITS'(1): ones = 4'd1;
      CMD_BITS'(2): ones = 4'd2;
      CMD_BITS'(3): ones = 4'd3;
      CMD_BITS'(4): begin tens = 4'd9; ones = 4'd0; end
      CMD_BITS'(5): begin tens = 4'd9; ones = 4'd1; end
      CMD_BITS'(6): begin letter = 8'h4D; ones = 4'd2; end
      default: ;
    endcase
    case (idx_q)
      2'd0:    char_d = letter;
      2'd1:    char_d = {4'h3, tens};
      2'd2:    char_d = {4'h3, ones};
`ifdef CMD_EMITTER_TRAILING_SPACE_EN
      2'd3:    char_d = 8'h20;
`endif
      default: char_d = 8'h00;
    endcase
  end

  // Emission FSM with registered outputs; reset wins over clk_en and trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      idx_q        <= 2'd0;
      rdy_q        <= 1'b1;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
      wr_trigger_q <= 1'b0;
      char_q       <= 8'h00;
    end else if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            cmd_q     <= cmd;
            success_q <= 1'b0;
            idx_q     <= 2'd0;
            rdy_q     <= 1'b0;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cmd_valid) begin
            state_q <= S_WAIT_RDY;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WAIT_RDY: begin
          if (wr_rdy) begin
            wr_trigger_q <= 1'b1;
            char_q       <= char_d;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_trigger_q <= 1'b0;
          state_q      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (wr_done) begin
            if (idx_q == LAST_IDX) begin
              success_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= S_WAIT_RDY;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          rdy_q        <= 1'b1;
          done_q       <= 1'b0;
          wr_trigger_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdy         = rdy_q;
  assign done        = done_q;
  assign success     = success_q;
  assign wr_trigger  = wr_trigger_q;
  assign char_out    = char_q;
  assign dbg_state_o = state_q;

endmodule
